// File: rtl/sba_mem_pkg.sv
// Shared definitions for the core/SBA memory arbiter.
// Defines the requester port ID enum and the number of requester ports.
package sba_mem_pkg;

    localparam int unsigned NumPorts = 2;

    typedef enum logic [$clog2(NumPorts)-1:0] {
        PortCore = 1'b0,
        PortSba  = 1'b1
    } port_e;

endpackage

// File: rtl/sba_id_fifo.sv
// In-order ID FIFO that remembers which port owns each granted-but-unanswered
// memory transfer.
// Ports: clk_i/rst_ni clock and async active-low reset; push_i/data_i write
// side; pop_i/data_o read side (data_o shows the head); full_o, empty_o and
// count_o report occupancy. A push when full or a pop when empty is ignored.
module sba_id_fifo #(
    parameter  int unsigned Depth = 2,
    localparam int unsigned CntW  = $clog2(Depth + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            push_i,
    input  logic            data_i,
    input  logic            pop_i,
    output logic            data_o,
    output logic            full_o,
    output logic            empty_o,
    output logic [CntW-1:0] count_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Depth-1:0] mem_q;
    logic [PtrW-1:0]  wptr_q, rptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push, do_pop;

    function automatic logic [PtrW-1:0] ptr_next(input logic [PtrW-1:0] ptr);
        return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + PtrW'(1);
    endfunction

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wptr_q] <= data_i;
                wptr_q        <= ptr_next(wptr_q);
            end
            if (do_pop) begin
                rptr_q <= ptr_next(rptr_q);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/sba_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between the core data port
// (port 0) and the debug-module system bus access port (port 1).
// Ports: clk_i/rst_ni; core_* and sba_* request/grant/response per port;
// mem_* shared memory request, grant and in-order response; rsp_err_o is a
// sticky flag raised when a memory response arrives with nothing outstanding.
module sba_mem_arbiter
    import sba_mem_pkg::*;
#(
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   core_req_i,
    input  logic                   core_we_i,
    input  logic [AddrWidth-1:0]   core_addr_i,
    input  logic [DataWidth/8-1:0] core_be_i,
    input  logic [DataWidth-1:0]   core_wdata_i,
    output logic                   core_gnt_o,
    output logic                   core_rvalid_o,
    output logic [DataWidth-1:0]   core_rdata_o,
    input  logic                   sba_req_i,
    input  logic                   sba_we_i,
    input  logic [AddrWidth-1:0]   sba_addr_i,
    input  logic [DataWidth/8-1:0] sba_be_i,
    input  logic [DataWidth-1:0]   sba_wdata_i,
    output logic                   sba_gnt_o,
    output logic                   sba_rvalid_o,
    output logic [DataWidth-1:0]   sba_rdata_o,
    output logic                   mem_req_o,
    output logic                   mem_we_o,
    output logic [AddrWidth-1:0]   mem_addr_o,
    output logic [DataWidth/8-1:0] mem_be_o,
    output logic [DataWidth-1:0]   mem_wdata_o,
    input  logic                   mem_gnt_i,
    input  logic                   mem_rvalid_i,
    input  logic [DataWidth-1:0]   mem_rdata_i,
    output logic                   rsp_err_o
);

    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

    port_e           sel, last_q, last_d, hold_port_q, hold_port_d, head_port;
    logic            hold_q, hold_d, err_q, err_d;
    logic            sel_req, xfer, pop;
    logic            fifo_full, fifo_empty, fifo_head;
    logic [CntW-1:0] fifo_count;

    // A stalled request keeps its port selected so the memory side sees a
    // stable request; otherwise ties go to the port not granted last.
    always_comb begin
        if (hold_q) begin
            sel = hold_port_q;
        end else if (core_req_i && sba_req_i) begin
            sel = (last_q == PortCore) ? PortSba : PortCore;
        end else if (sba_req_i) begin
            sel = PortSba;
        end else begin
            sel = PortCore;
        end
    end

    assign sel_req = (sel == PortCore) ? core_req_i : sba_req_i;

    // Full blocks on the registered count only, so a response arriving this
    // cycle cannot re-open the request path combinationally.
    assign mem_req_o   = rst_ni && sel_req && !fifo_full;
    assign mem_we_o    = (sel == PortCore) ? core_we_i    : sba_we_i;
    assign mem_addr_o  = (sel == PortCore) ? core_addr_i  : sba_addr_i;
    assign mem_be_o    = (sel == PortCore) ? core_be_i    : sba_be_i;
    assign mem_wdata_o = (sel == PortCore) ? core_wdata_i : sba_wdata_i;

    assign xfer       = mem_req_o && mem_gnt_i;
    assign core_gnt_o = xfer && (sel == PortCore);
    assign sba_gnt_o  = xfer && (sel == PortSba);

    assign pop           = rst_ni && mem_rvalid_i && !fifo_empty;
    assign head_port     = port_e'(fifo_head);
    assign core_rvalid_o = pop && (head_port == PortCore);
    assign sba_rvalid_o  = pop && (head_port == PortSba);
    assign core_rdata_o  = mem_rdata_i;
    assign sba_rdata_o   = mem_rdata_i;
    assign rsp_err_o     = err_q;

    always_comb begin
        hold_d      = mem_req_o && !mem_gnt_i;
        hold_port_d = sel;
        last_d      = xfer ? sel : last_q;
        err_d       = err_q || (mem_rvalid_i && fifo_empty);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q      <= PortSba;
            hold_q      <= 1'b0;
            hold_port_q <= PortCore;
            err_q       <= 1'b0;
        end else begin
            last_q      <= last_d;
            hold_q      <= hold_d;
            hold_port_q <= hold_port_d;
            err_q       <= err_d;
        end
    end

    sba_id_fifo #(
        .Depth (MaxOutstanding)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (xfer),
        .data_i  (logic'(sel)),
        .pop_i   (pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    a_count_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
        fifo_count <= CntW'(MaxOutstanding));
    a_gnt_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(core_gnt_o && sba_gnt_o));

endmodule

// File: tb/tb_sba_mem_arbiter.sv
module tb_sba_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        core_req, core_we, sba_req, sba_we;
    logic [31:0] core_addr, sba_addr, core_wdata, sba_wdata;
    logic [3:0]  core_be, sba_be;
    logic        core_gnt, core_rvalid, sba_gnt, sba_rvalid;
    logic [31:0] core_rdata, sba_rdata;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid, rsp_err;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    sba_mem_arbiter dut (
        .clk_i(clk), .rst_ni(rst_n),
        .core_req_i(core_req), .core_we_i(core_we), .core_addr_i(core_addr),
        .core_be_i(core_be), .core_wdata_i(core_wdata),
        .core_gnt_o(core_gnt), .core_rvalid_o(core_rvalid), .core_rdata_o(core_rdata),
        .sba_req_i(sba_req), .sba_we_i(sba_we), .sba_addr_i(sba_addr),
        .sba_be_i(sba_be), .sba_wdata_i(sba_wdata),
        .sba_gnt_o(sba_gnt), .sba_rvalid_o(sba_rvalid), .sba_rdata_o(sba_rdata),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_be_o(mem_be), .mem_wdata_o(mem_wdata),
        .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
        .rsp_err_o(rsp_err)
    );

    task automatic idle();
        core_req = 0; core_we = 0; core_addr = 32'h1000_0000; core_be = 4'hF; core_wdata = 32'hC0DE_0000;
        sba_req = 0; sba_we = 0; sba_addr = 32'h2000_0000; sba_be = 4'h3; sba_wdata = 32'h5BA0_0000;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = 32'h0;
    endtask

    // Advance to just after the next rising edge; stimulus is then applied.
    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic apply_reset();
        next_cycle();
        idle();
        rst_n = 0;
        next_cycle();
        next_cycle();
        rst_n = 1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle();
        core_req = 1; sba_req = 1; mem_gnt = 1; mem_rvalid = 1; mem_rdata = 32'hDEAD_BEEF;
        #1;
        total_cnt++; if (mem_req !== 1'b0) $display("FAIL rst_mem_req: got %b exp 0", mem_req); else pass_cnt++;
        total_cnt++; if ({core_gnt, sba_gnt} !== 2'b00) $display("FAIL rst_gnt: got %b exp 00", {core_gnt, sba_gnt}); else pass_cnt++;
        total_cnt++; if ({core_rvalid, sba_rvalid} !== 2'b00) $display("FAIL rst_rvalid: got %b exp 00", {core_rvalid, sba_rvalid}); else pass_cnt++;
        total_cnt++; if (rsp_err !== 1'b0) $display("FAIL rst_err: got %b exp 0", rsp_err); else pass_cnt++;
        apply_reset();
    endtask

    task automatic test_round_robin();
        apply_reset();
        core_req = 1; sba_req = 1; mem_gnt = 1; core_addr = 32'h1000_0010; sba_addr = 32'h2000_0020;
        #1;
        total_cnt++; if ({core_gnt, sba_gnt} !== 2'b10) $display("FAIL rr_gnt0: got %b exp 10", {core_gnt, sba_gnt}); else pass_cnt++;
        total_cnt++; if (mem_addr !== 32'h1000_0010) $display("FAIL rr_addr0: got %h exp 10000010", mem_addr); else pass_cnt++;
        next_cycle();
        mem_rvalid = 1; mem_rdata = 32'hAAAA_0001;
        #1;
        total_cnt++; if ({core_gnt, sba_gnt} !== 2'b01) $display("FAIL rr_gnt1: got %b exp 01", {core_gnt, sba_gnt}); else pass_cnt++;
        total_cnt++; if ({core_rvalid, sba_rvalid} !== 2'b10) $display("FAIL rr_rv1: got %b exp 10", {core_rvalid, sba_rvalid}); else pass_cnt++;
        total_cnt++; if (mem_addr !== 32'h2000_0020 || mem_be !== 4'h3) $display("FAIL rr_mux1: got %h/%h exp 20000020/3", mem_addr, mem_be); else pass_cnt++;
        total_cnt++; if (core_rdata !== 32'hAAAA_0001 || sba_rdata !== 32'hAAAA_0001) $display("FAIL rr_rdata1: got %h/%h exp aaaa0001", core_rdata, sba_rdata); else pass_cnt++;
        next_cycle();
        mem_rdata = 32'hAAAA_0002;
        #1;
        total_cnt++; if ({core_gnt, sba_gnt} !== 2'b10) $display("FAIL rr_gnt2: got %b exp 10", {core_gnt, sba_gnt}); else pass_cnt++;
        total_cnt++; if ({core_rvalid, sba_rvalid} !== 2'b01) $display("FAIL rr_rv2: got %b exp 01", {core_rvalid, sba_rvalid}); else pass_cnt++;
        next_cycle();
        core_req = 0; sba_req = 0; mem_gnt = 0; mem_rdata = 32'hAAAA_0003;
        #1;
        total_cnt++; if ({core_rvalid, sba_rvalid} !== 2'b10) $display("FAIL rr_rv3: got %b exp 10", {core_rvalid, sba_rvalid}); else pass_cnt++;
        next_cycle();
        mem_rvalid = 0;
        #1;
        total_cnt++; if (rsp_err !== 1'b0) $display("FAIL rr_err: got %b exp 0", rsp_err); else pass_cnt++;
    endtask

    task automatic test_hold();
        apply_reset();
        sba_req = 1; sba_addr = 32'h2000_0040; core_addr = 32'h1000_0040; mem_gnt = 0;
        #1;
        total_cnt++; if (mem_req !== 1'b1 || mem_addr !== 32'h2000_0040) $display("FAIL hold_c0: got %b/%h exp 1/20000040", mem_req, mem_addr); else pass_cnt++;
        next_cycle();
        core_req = 1;
        #1;
        total_cnt++; if (mem_addr !== 32'h2000_0040 || core_gnt !== 1'b0) $display("FAIL hold_c1: got %h/%b exp 20000040/0", mem_addr, core_gnt); else pass_cnt++;
        next_cycle();
        #1;
        total_cnt++; if (mem_addr !== 32'h2000_0040) $display("FAIL hold_c2: got %h exp 20000040", mem_addr); else pass_cnt++;
        next_cycle();
        mem_gnt = 1;
        #1;
        total_cnt++; if ({core_gnt, sba_gnt} !== 2'b01) $display("FAIL hold_gnt3: got %b exp 01", {core_gnt, sba_gnt}); else pass_cnt++;
        next_cycle();
        sba_req = 0; mem_rvalid = 1;
        #1;
        total_cnt++; if ({core_gnt, sba_gnt} !== 2'b10 || mem_addr !== 32'h1000_0040) $display("FAIL hold_gnt4: got %b/%h exp 10/10000040", {core_gnt, sba_gnt}, mem_addr); else pass_cnt++;
        total_cnt++; if ({core_rvalid, sba_rvalid} !== 2'b01) $display("FAIL hold_rv4: got %b exp 01", {core_rvalid, sba_rvalid}); else pass_cnt++;
        next_cycle();
        core_req = 0; mem_gnt = 0;
        #1;
        total_cnt++; if ({core_rvalid, sba_rvalid} !== 2'b10) $display("FAIL hold_rv5: got %b exp 10", {core_rvalid, sba_rvalid}); else pass_cnt++;
        next_cycle();
        mem_rvalid = 0;
    endtask

    task automatic test_back_to_back();
        apply_reset();
        core_req = 1; mem_gnt = 1; core_addr = 32'h1000_0100;
        #1;
        total_cnt++; if (core_gnt !== 1'b1) $display("FAIL b2b_gnt0: got %b exp 1", core_gnt); else pass_cnt++;
        next_cycle();
        core_addr = 32'h1000_0104;
        #1;
        total_cnt++; if (core_gnt !== 1'b1) $display("FAIL b2b_gnt1: got %b exp 1", core_gnt); else pass_cnt++;
        next_cycle();
        core_addr = 32'h1000_0108;
        #1;
        total_cnt++; if (mem_req !== 1'b0 || core_gnt !== 1'b0) $display("FAIL b2b_full2: got %b/%b exp 0/0", mem_req, core_gnt); else pass_cnt++;
        next_cycle();
        #1;
        total_cnt++; if (mem_req !== 1'b0) $display("FAIL b2b_full3: got %b exp 0", mem_req); else pass_cnt++;
        next_cycle();
        mem_rvalid = 1;
        #1;
        total_cnt++; if (core_rvalid !== 1'b1 || mem_req !== 1'b0) $display("FAIL b2b_pop4: got rv=%b req=%b exp 1/0", core_rvalid, mem_req); else pass_cnt++;
        next_cycle();
        #1;
        total_cnt++; if (core_gnt !== 1'b1 || mem_addr !== 32'h1000_0108) $display("FAIL b2b_gnt5: got %b/%h exp 1/10000108", core_gnt, mem_addr); else pass_cnt++;
        total_cnt++; if (core_rvalid !== 1'b1) $display("FAIL b2b_rv5: got %b exp 1", core_rvalid); else pass_cnt++;
        next_cycle();
        core_req = 0; mem_gnt = 0; mem_rvalid = 0;
        next_cycle();
        next_cycle();
        next_cycle();
        mem_rvalid = 1;
        #1;
        total_cnt++; if (core_rvalid !== 1'b1) $display("FAIL b2b_rv9: got %b exp 1", core_rvalid); else pass_cnt++;
        next_cycle();
        mem_rvalid = 0;
        #1;
        total_cnt++; if (rsp_err !== 1'b0) $display("FAIL b2b_err: got %b exp 0", rsp_err); else pass_cnt++;
    endtask

    task automatic test_same_cycle();
        apply_reset();
        core_req = 1; mem_gnt = 1;
        next_cycle();
        core_req = 0; sba_req = 1; mem_rvalid = 1;
        #1;
        total_cnt++; if ({core_rvalid, sba_rvalid} !== 2'b10 || sba_gnt !== 1'b1) $display("FAIL same_c1: got rv=%b gnt=%b exp 10/1", {core_rvalid, sba_rvalid}, sba_gnt); else pass_cnt++;
        next_cycle();
        sba_req = 0; mem_gnt = 0;
        #1;
        total_cnt++; if ({core_rvalid, sba_rvalid} !== 2'b01) $display("FAIL same_c2: got %b exp 01", {core_rvalid, sba_rvalid}); else pass_cnt++;
        next_cycle();
        mem_rvalid = 0;
        #1;
        total_cnt++; if (rsp_err !== 1'b0) $display("FAIL same_err: got %b exp 0", rsp_err); else pass_cnt++;
    endtask

    task automatic test_stray_rvalid();
        apply_reset();
        mem_rvalid = 1;
        #1;
        total_cnt++; if ({core_rvalid, sba_rvalid} !== 2'b00) $display("FAIL stray_rv: got %b exp 00", {core_rvalid, sba_rvalid}); else pass_cnt++;
        next_cycle();
        mem_rvalid = 0;
        #1;
        total_cnt++; if (rsp_err !== 1'b1) $display("FAIL stray_err: got %b exp 1", rsp_err); else pass_cnt++;
        core_req = 1; mem_gnt = 1;
        next_cycle();
        core_req = 0; mem_gnt = 0; mem_rvalid = 1;
        #1;
        total_cnt++; if (core_rvalid !== 1'b1) $display("FAIL stray_rv_after: got %b exp 1", core_rvalid); else pass_cnt++;
        next_cycle();
        mem_rvalid = 0;
        next_cycle();
        next_cycle();
        total_cnt++; if (rsp_err !== 1'b1) $display("FAIL stray_sticky: got %b exp 1", rsp_err); else pass_cnt++;
        rst_n = 0;
        #1;
        total_cnt++; if (rsp_err !== 1'b0) $display("FAIL stray_clr: got %b exp 0", rsp_err); else pass_cnt++;
        next_cycle();
        rst_n = 1;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        core_req = 1; sba_req = 1; mem_gnt = 1;
        next_cycle();
        next_cycle();
        mem_rvalid = 1;
        rst_n = 0;
        #1;
        total_cnt++; if ({mem_req, core_gnt, sba_gnt} !== 3'b000) $display("FAIL mid_req_gnt: got %b exp 000", {mem_req, core_gnt, sba_gnt}); else pass_cnt++;
        total_cnt++; if ({core_rvalid, sba_rvalid, rsp_err} !== 3'b000) $display("FAIL mid_rv_err: got %b exp 000", {core_rvalid, sba_rvalid, rsp_err}); else pass_cnt++;
        next_cycle();
        rst_n = 1; core_req = 0; sba_req = 0; mem_gnt = 0;
        #1;
        total_cnt++; if ({core_rvalid, sba_rvalid} !== 2'b00) $display("FAIL mid_stale_rv: got %b exp 00", {core_rvalid, sba_rvalid}); else pass_cnt++;
        next_cycle();
        mem_rvalid = 0; core_req = 1; sba_req = 1; mem_gnt = 1;
        #1;
        total_cnt++; if (rsp_err !== 1'b1) $display("FAIL mid_stale_err: got %b exp 1", rsp_err); else pass_cnt++;
        total_cnt++; if ({core_gnt, sba_gnt} !== 2'b10) $display("FAIL mid_tie: got %b exp 10", {core_gnt, sba_gnt}); else pass_cnt++;
        next_cycle();
        idle();
    endtask

    initial begin
        idle();
        rst_n = 0;
        test_reset();
        test_round_robin();
        test_hold();
        test_back_to_back();
        test_same_cycle();
        test_stray_rvalid();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
